// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Purpose:
//   Direct-mapped branch target buffer with a 2-bit saturating counter per
//   entry. Lookup is combinational from Fetch_PC against the registered
//   table. Resolved branches from ID update the table on the next rising
//   edge, so a lookup and an update to the same entry in one cycle returns
//   the pre-update contents. The block also keeps saturating counters of
//   resolved and mispredicted branches.
//
// Optional build macro:
//   GSHARE_EN - when defined, an INDEX_BITS-wide global history register
//               shifts in Update_Taken on each Update_Valid. Both the lookup
//               and the update index become PC[INDEX_BITS+1:2] XOR history,
//               using the history value from before that cycle's shift.
//               Tags are not affected. When undefined, no history register
//               exists and the index is PC[INDEX_BITS+1:2].
//
// Ports:
//   CLK               in   1   clock, all state changes on its rising edge
//   RESET             in   1   synchronous, active-low reset
//   Fetch_PC          in  32   PC presented by IF
//   Predict_Taken     out  1   Fetch_PC predicted to be a taken branch
//   Predict_PC        out 32   predicted next fetch PC
//   Update_Valid      in   1   a branch was resolved in ID this cycle
//   Update_PC         in  32   PC of the resolved branch
//   Update_Taken      in   1   actual outcome
//   Update_Target     in  32   actual taken target
//   Update_Mispredict in   1   earlier prediction was wrong (with Update_Valid)
//   Branch_Count      out 16   resolved branches, saturating
//   Mispredict_Count  out 16   mispredicted branches, saturating
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int INDEX_BITS = 6
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Fetch_PC,
  output logic        Predict_Taken,
  output logic [31:0] Predict_PC,
  input  logic        Update_Valid,
  input  logic [31:0] Update_PC,
  input  logic        Update_Taken,
  input  logic [31:0] Update_Target,
  input  logic        Update_Mispredict,
  output logic [15:0] Branch_Count,
  output logic [15:0] Mispredict_Count
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = 32 - INDEX_BITS - 2;

  // Table state, one element per entry.
  logic                  valid_reg  [ENTRIES];
  logic [TAG_BITS-1:0]   tag_reg    [ENTRIES];
  logic [31:0]           target_reg [ENTRIES];
  logic [1:0]            ctr_reg    [ENTRIES];

  logic [15:0]           branch_count_reg;
  logic [15:0]           mispredict_count_reg;

  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] update_idx;
  logic [TAG_BITS-1:0]   lookup_tag;
  logic [TAG_BITS-1:0]   update_tag;

  logic                  lookup_hit;
  logic                  update_hit;
  logic [1:0]            ctr_next;

  // PC[1:0] never takes part in indexing or tagging.
  logic                  unused_pc_bits;
  assign unused_pc_bits = ^{Fetch_PC[1:0], Update_PC[1:0]};

  assign lookup_tag = Fetch_PC[31:INDEX_BITS+2];
  assign update_tag = Update_PC[31:INDEX_BITS+2];

`ifdef GSHARE_EN
  logic [INDEX_BITS-1:0] history_reg;
  logic [INDEX_BITS-1:0] history_next;

  // Both indices use the history as it stands before this cycle's shift.
  assign lookup_idx   = Fetch_PC[INDEX_BITS+1:2] ^ history_reg;
  assign update_idx   = Update_PC[INDEX_BITS+1:2] ^ history_reg;
  assign history_next = (history_reg << 1) | INDEX_BITS'(Update_Taken);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      history_reg <= '0;
    end else if (Update_Valid) begin
      history_reg <= history_next;
    end
  end
`else
  assign lookup_idx = Fetch_PC[INDEX_BITS+1:2];
  assign update_idx = Update_PC[INDEX_BITS+1:2];
`endif

  // Two-bit saturating step: up when taken, down when not taken.
  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    if (up) begin
      return (c == 2'b11) ? c : c + 2'd1;
    end
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // Lookup path, purely combinational from the registered table.
  always_comb begin
    lookup_hit    = valid_reg[lookup_idx] && (tag_reg[lookup_idx] == lookup_tag);
    Predict_Taken = lookup_hit && ctr_reg[lookup_idx][1];
    Predict_PC    = Predict_Taken ? target_reg[lookup_idx] : Fetch_PC + 32'd4;
  end

  always_comb begin
    update_hit = valid_reg[update_idx] && (tag_reg[update_idx] == update_tag);
    ctr_next   = sat_step(ctr_reg[update_idx], Update_Taken);
  end

  // One write port shared by all entries; each entry only reacts when the
  // update index selects it. Reset wins over any concurrent update.
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    logic entry_sel;
    assign entry_sel = Update_Valid && (update_idx == INDEX_BITS'(gi));

    always_ff @(posedge CLK) begin
      if (!RESET) begin
        valid_reg[gi]  <= 1'b0;
        tag_reg[gi]    <= '0;
        target_reg[gi] <= '0;
        ctr_reg[gi]    <= 2'b01;
      end else if (entry_sel) begin
        if (update_hit) begin
          ctr_reg[gi] <= ctr_next;
          if (Update_Taken) begin
            target_reg[gi] <= Update_Target;
          end
        end else if (Update_Taken) begin
          // Miss on a taken branch allocates or replaces, weakly taken.
          valid_reg[gi]  <= 1'b1;
          tag_reg[gi]    <= update_tag;
          target_reg[gi] <= Update_Target;
          ctr_reg[gi]    <= 2'b10;
        end
      end
    end
  end

  // Statistics counters, saturating at all ones.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      branch_count_reg     <= '0;
      mispredict_count_reg <= '0;
    end else if (Update_Valid) begin
      if (branch_count_reg != 16'hFFFF) begin
        branch_count_reg <= branch_count_reg + 16'd1;
      end
      if (Update_Mispredict && (mispredict_count_reg != 16'hFFFF)) begin
        mispredict_count_reg <= mispredict_count_reg + 16'd1;
      end
    end
  end

  assign Branch_Count     = branch_count_reg;
  assign Mispredict_Count = mispredict_count_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed stimulus for branch_predictor in its default build. The driver
// sets inputs just after each rising edge and, for checked cycles, pushes the
// hand-computed response into a queue. A monitor samples on the falling edge,
// pops one expectation and compares the outputs against it.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Fetch_PC;
  logic        Predict_Taken;
  logic [31:0] Predict_PC;
  logic        Update_Valid;
  logic [31:0] Update_PC;
  logic        Update_Taken;
  logic [31:0] Update_Target;
  logic        Update_Mispredict;
  logic [15:0] Branch_Count;
  logic [15:0] Mispredict_Count;

  branch_predictor #(.INDEX_BITS(6)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .Fetch_PC          (Fetch_PC),
    .Predict_Taken     (Predict_Taken),
    .Predict_PC        (Predict_PC),
    .Update_Valid      (Update_Valid),
    .Update_PC         (Update_PC),
    .Update_Taken      (Update_Taken),
    .Update_Target     (Update_Target),
    .Update_Mispredict (Update_Mispredict),
    .Branch_Count      (Branch_Count),
    .Mispredict_Count  (Mispredict_Count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        taken;
    logic [31:0] pc;
    logic [15:0] bc;
    logic [15:0] mc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Monitor: one expectation per checked cycle, sampled mid-cycle.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("txn %s: fetch=%h taken=%0d pc=%h bc=%0d mc=%0d",
               e.name, Fetch_PC, Predict_Taken, Predict_PC, Branch_Count, Mispredict_Count);
      checks++;
      if (Predict_Taken === e.taken) passes++;
      else $display("FAIL %s.taken got=%0d want=%0d", e.name, Predict_Taken, e.taken);
      checks++;
      if (Predict_PC === e.pc) passes++;
      else $display("FAIL %s.pc got=%h want=%h", e.name, Predict_PC, e.pc);
      checks++;
      if (Branch_Count === e.bc) passes++;
      else $display("FAIL %s.branch_count got=%0d want=%0d", e.name, Branch_Count, e.bc);
      checks++;
      if (Mispredict_Count === e.mc) passes++;
      else $display("FAIL %s.mispredict_count got=%0d want=%0d", e.name, Mispredict_Count, e.mc);
    end
  end

  // Drive one cycle; optionally queue the response expected during it.
  task automatic step(input logic rst, input logic uv, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utgt, input logic umis,
                      input logic [31:0] fpc, input bit chk, input string name,
                      input logic et, input logic [31:0] epc,
                      input logic [15:0] ebc, input logic [15:0] emc);
    exp_t e;
    @(posedge CLK);
    #1;
    RESET             = rst;
    Update_Valid      = uv;
    Update_PC         = upc;
    Update_Taken      = ut;
    Update_Target     = utgt;
    Update_Mispredict = umis;
    Fetch_PC          = fpc;
    if (chk) begin
      e.name = name; e.taken = et; e.pc = epc; e.bc = ebc; e.mc = emc;
      exp_q.push_back(e);
    end
  endtask

  localparam logic [31:0] PA  = 32'h0040_0010;
  localparam logic [31:0] PAL = 32'h0040_1010;  // aliases PA's index, different tag

  initial begin
    RESET = 1'b0; Update_Valid = 0; Update_PC = 0; Update_Taken = 0;
    Update_Target = 0; Update_Mispredict = 0; Fetch_PC = 0;

    step(0, 0, 0, 0, 0, 0, 0, 0, "", 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, "", 0, 0, 0, 0);

    //   rst uv upc ut target mis fetch chk name taken pc bc mc
    step(1, 0, 0,  0, 0, 0, PA, 1, "reset_state", 0, 32'h0040_0014, 0, 0);
    // Allocating update: same-cycle lookup still sees the old entry.
    step(1, 1, PA, 1, 32'h0040_0100, 1, PA, 1, "alloc_same_cycle", 0, 32'h0040_0014, 0, 0);
    step(1, 0, 0,  0, 0, 0, PA, 1, "alloc_visible", 1, 32'h0040_0100, 1, 1);
    // Counter 2 -> 1 -> 0 -> 0 (saturate low).
    step(1, 1, PA, 0, 0, 0, PA, 1, "nt1_ctr2", 1, 32'h0040_0100, 1, 1);
    step(1, 1, PA, 0, 0, 0, PA, 1, "nt2_ctr1", 0, 32'h0040_0014, 2, 1);
    step(1, 1, PA, 0, 0, 0, PA, 1, "nt3_ctr0", 0, 32'h0040_0014, 3, 1);
    // From 0, one taken gives 1 (not taken); a second gives 2 (taken).
    step(1, 1, PA, 1, 32'h0040_0200, 0, PA, 1, "t_from0", 0, 32'h0040_0014, 4, 1);
    step(1, 1, PA, 1, 32'h0040_0300, 0, PA, 1, "ctr1", 0, 32'h0040_0014, 5, 1);
    // Counter 2 -> 3 -> 3 (saturate high), then down 3 -> 2 -> 1.
    step(1, 1, PA, 1, 32'h0040_0300, 0, PA, 1, "ctr2_tgt", 1, 32'h0040_0300, 6, 1);
    step(1, 1, PA, 1, 32'h0040_0300, 0, PA, 1, "ctr3", 1, 32'h0040_0300, 7, 1);
    step(1, 1, PA, 0, 0, 0, PA, 1, "ctr3_sat", 1, 32'h0040_0300, 8, 1);
    step(1, 1, PA, 0, 0, 0, PA, 1, "ctr2_down", 1, 32'h0040_0300, 9, 1);
    step(1, 0, 0,  0, 0, 0, PA, 1, "ctr1_down", 0, 32'h0040_0014, 10, 1);
    // Back to counter 2, then replace with the alias tag.
    step(1, 1, PA, 1, 32'h0040_0100, 0, PA, 1, "re_up", 0, 32'h0040_0014, 10, 1);
    step(1, 1, PAL, 1, 32'h0040_1100, 0, PA, 1, "alias_upd", 1, 32'h0040_0100, 11, 1);
    step(1, 0, 0,  0, 0, 0, PA,  1, "alias_old_miss", 0, 32'h0040_0014, 12, 1);
    step(1, 0, 0,  0, 0, 0, PAL, 1, "alias_new_hit", 1, 32'h0040_1100, 12, 1);
    // Same-cycle lookup and taken update on an invalid entry.
    step(1, 1, 32'h0040_0020, 1, 32'h0040_0500, 0, 32'h0040_0020, 1, "same_cyc_old", 0, 32'h0040_0024, 12, 1);
    step(1, 0, 0, 0, 0, 0, 32'h0040_0020, 1, "same_cyc_new", 1, 32'h0040_0500, 13, 1);
    // Not-taken miss must not allocate; mispredict without valid is ignored.
    step(1, 1, 32'h0040_0030, 0, 32'h0000_0999, 0, 32'h0040_0030, 1, "nt_miss", 0, 32'h0040_0034, 13, 1);
    step(1, 0, 32'h0040_0030, 1, 32'h0000_0999, 1, 32'h0040_0030, 1, "mis_no_valid", 0, 32'h0040_0034, 14, 1);
    step(1, 0, 0, 0, 0, 0, 32'h0040_0030, 1, "nt_miss_after", 0, 32'h0040_0034, 14, 1);
    step(1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, "pc_wrap", 0, 32'h0000_0000, 14, 1);
    // Reset wins over a concurrent update.
    step(0, 1, 32'h0040_0050, 1, 32'h0040_0700, 1, 32'h0040_0050, 1, "rst_with_upd", 0, 32'h0040_0054, 14, 1);
    step(1, 0, 0, 0, 0, 0, 32'h0040_0050, 1, "rst_upd_dropped", 0, 32'h0040_0054, 0, 0);
    step(1, 0, 0, 0, 0, 0, 32'h0040_0020, 1, "rst_cleared", 0, 32'h0040_0024, 0, 0);

    // Count saturation.
    for (int i = 0; i < 70000; i++) begin
      step(1, 1, 32'h0040_0060, 0, 0, 1, 32'h0040_0060, 0, "", 0, 0, 0, 0);
    end
    step(1, 0, 0, 0, 0, 0, 32'h0040_0060, 1, "count_sat", 0, 32'h0040_0064, 16'hFFFF, 16'hFFFF);
    step(1, 1, 32'h0040_0060, 0, 0, 1, 32'h0040_0060, 1, "count_hold", 0, 32'h0040_0064, 16'hFFFF, 16'hFFFF);
    step(0, 0, 0, 0, 0, 0, 32'h0040_0060, 1, "count_rst_edge", 0, 32'h0040_0064, 16'hFFFF, 16'hFFFF);
    step(1, 0, 0, 0, 0, 0, 32'h0040_0060, 1, "count_cleared", 0, 32'h0040_0064, 0, 0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    @(posedge CLK);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
